// File: rtl/kernel_fetch_sequencer.sv
// Kernel fetch sequencer: on start, issues KernelRows read requests to the memory
// access controller, assembles the returned rows into one kernel word, and reports
// done or a timeout error.
module kernel_fetch_sequencer #(
  parameter int unsigned KernelRows = 3,
  parameter int unsigned RowStride  = 3,
  parameter logic [1:0]  MaOp       = 2'b00,
  parameter int unsigned Timeout    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [47:0]             kernel_base_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    kernel_valid_o,
  output logic [48*KernelRows-1:0] kernel_o,
  output logic                    ma_enable_o,
  output logic [2:0]              ma_ctrl_o,
  output logic [47:0]             ma_address_o,
  input  logic [47:0]             ma_read_i,
  input  logic                    ma_handshake_i
);

  localparam int unsigned RowW   = (KernelRows > 1) ? $clog2(KernelRows) : 1;
  localparam int unsigned TimerW = $clog2(Timeout + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StGap,
    StDone,
    StErr
  } state_e;

  state_e                  state_q, state_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [47:0]             base_q, base_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    kvalid_q, kvalid_d;
  logic [48*KernelRows-1:0] kernel_q, kernel_d;
  logic                    en_q, en_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [47:0]             addr_q, addr_d;

  logic [47:0]             row_offset;
  logic                    last_row;
  logic                    timer_last;

  // Address arithmetic wraps modulo 2^48 by truncation.
  assign row_offset = 48'(row_q) * 48'(RowStride);
  assign last_row   = (row_q == RowW'(KernelRows - 1));
  assign timer_last = (timer_q == TimerW'(Timeout - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    timer_d  = timer_q;
    base_d   = base_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    kvalid_d = kvalid_q;
    kernel_d = kernel_q;
    en_d     = en_q;
    ctrl_d   = ctrl_q;
    addr_d   = addr_q;

    unique case (state_q)
      StIdle, StErr: begin
        if (start_i) begin
          base_d   = kernel_base_i;
          row_d    = '0;
          busy_d   = 1'b1;
          kvalid_d = 1'b0;
          error_d  = 1'b0;
          state_d  = StReq;
        end
      end
      StReq: begin
        addr_d  = base_q + row_offset;
        ctrl_d  = {MaOp, 1'b0};
        en_d    = 1'b1;
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // A handshake wins over a simultaneous timer expiry.
        if (ma_handshake_i) begin
          for (int unsigned r = 0; r < KernelRows; r++) begin
            if (row_q == RowW'(r)) begin
              kernel_d[48*r +: 48] = ma_read_i;
            end
          end
          en_d    = 1'b0;
          state_d = StGap;
        end else if (timer_last) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = StErr;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        // Controller must drop its handshake before the next request goes out.
        if (!ma_handshake_i) begin
          if (last_row) begin
            done_d   = 1'b1;
            kvalid_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = StDone;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StReq;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      row_q    <= '0;
      timer_q  <= '0;
      base_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      kvalid_q <= 1'b0;
      kernel_q <= '0;
      en_q     <= 1'b0;
      ctrl_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      timer_q  <= timer_d;
      base_q   <= base_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      kvalid_q <= kvalid_d;
      kernel_q <= kernel_d;
      en_q     <= en_d;
      ctrl_q   <= ctrl_d;
      addr_q   <= addr_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign kernel_valid_o = kvalid_q;
  assign kernel_o       = kernel_q;
  assign ma_enable_o    = en_q;
  assign ma_ctrl_o      = ctrl_q;
  assign ma_address_o   = addr_q;

endmodule

// File: tb/tb_kernel_fetch_sequencer.sv
// Self-checking bench for kernel_fetch_sequencer with a behavioural controller model.
module tb_kernel_fetch_sequencer;

  localparam int TbTimeout = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [47:0]  kernel_base_i = '0;
  logic         busy_o, done_o, error_o, kernel_valid_o;
  logic [143:0] kernel_o;
  logic         ma_enable_o;
  logic [2:0]   ma_ctrl_o;
  logic [47:0]  ma_address_o;
  logic [47:0]  ma_read_i = '0;
  logic         ma_handshake_i = 1'b0;

  kernel_fetch_sequencer #(
    .KernelRows(3),
    .RowStride (3),
    .MaOp      (2'b00),
    .Timeout   (TbTimeout)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .kernel_base_i (kernel_base_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .kernel_valid_o(kernel_valid_o),
    .kernel_o      (kernel_o),
    .ma_enable_o   (ma_enable_o),
    .ma_ctrl_o     (ma_ctrl_o),
    .ma_address_o  (ma_address_o),
    .ma_read_i     (ma_read_i),
    .ma_handshake_i(ma_handshake_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Controller model configuration per request: handshake delay (0 = never),
  // handshake hold after enable falls, and read data.
  int          cfg_d [4];
  int          cfg_g [4];
  logic [47:0] cfg_data [4];
  logic [47:0] req_addr [$];
  logic [2:0]  req_ctrl [$];
  int          req_n = 0;
  int          cur = 0;
  int          en_cnt = 0;
  int          low_cnt = 0;
  int          gap_viol = 0;
  bit          en_prev = 1'b0;

  // Observations from the last run_load.
  int obs_lat, obs_ndone, obs_err_lat;
  bit obs_err, obs_busy_acc, obs_kv_acc, obs_err_acc, obs_busy_end;

  // Memory controller model.
  always @(posedge clk_i) begin
    logic [63:0] junk;
    #1;
    if (ma_enable_o && !en_prev) begin
      if (ma_handshake_i) gap_viol++;
      req_addr.push_back(ma_address_o);
      req_ctrl.push_back(ma_ctrl_o);
      cur = (req_n < 4) ? req_n : 3;
      req_n++;
      en_cnt = 0;
    end
    if (ma_enable_o) begin
      en_cnt++;
      if (!ma_handshake_i && cfg_d[cur] != 0 && en_cnt == cfg_d[cur]) begin
        ma_handshake_i = 1'b1;
        ma_read_i = cfg_data[cur];
        low_cnt = 0;
      end
    end else if (ma_handshake_i) begin
      low_cnt++;
      if (low_cnt >= cfg_g[cur]) ma_handshake_i = 1'b0;
    end
    if (!ma_handshake_i) begin
      junk = {$urandom(), $urandom()};
      ma_read_i = junk[47:0];
    end
    en_prev = ma_enable_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    req_addr.delete();
    req_ctrl.delete();
    req_n = 0;
    gap_viol = 0;
  endtask

  task automatic set_cfg(input int d0, input int d1, input int d2, input int g,
                         input logic [47:0] r0, input logic [47:0] r1,
                         input logic [47:0] r2);
    cfg_d[0] = d0; cfg_d[1] = d1; cfg_d[2] = d2; cfg_d[3] = 1;
    for (int i = 0; i < 4; i++) cfg_g[i] = g;
    cfg_data[0] = r0; cfg_data[1] = r1; cfg_data[2] = r2; cfg_data[3] = '0;
  endtask

  // Drives one START and follows the load to DONE, ERROR or a cycle budget.
  task automatic run_load(input logic [47:0] base, input bit spam);
    logic [63:0] junk;
    model_clear();
    kernel_base_i = base;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    junk = {$urandom(), $urandom()};
    kernel_base_i = junk[47:0];
    obs_busy_acc = busy_o;
    obs_kv_acc = kernel_valid_o;
    obs_err_acc = error_o;
    obs_lat = -1;
    obs_ndone = 0;
    obs_err = 1'b0;
    obs_err_lat = -1;
    obs_busy_end = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (spam) start_i = 1'($urandom_range(0, 1));
      tick();
      if (done_o) begin
        obs_ndone++;
        obs_lat = cyc;
        obs_busy_end = busy_o;
        break;
      end
      if (error_o) begin
        obs_err = 1'b1;
        obs_err_lat = cyc;
        break;
      end
    end
    start_i = 1'b0;
    repeat (3) begin
      tick();
      if (done_o) obs_ndone++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", error_o); end
    n_vec++; if (kernel_valid_o !== 1'b0) begin n_err++;
      $display("FAIL reset_kvalid: got %b want 0", kernel_valid_o); end
    n_vec++; if (kernel_o !== 144'd0) begin n_err++; $display("FAIL reset_kernel: got %h want 0", kernel_o); end
    n_vec++; if (ma_enable_o !== 1'b0) begin n_err++;
      $display("FAIL reset_enable: got %b want 0", ma_enable_o); end
    n_vec++; if (ma_ctrl_o !== 3'd0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", ma_ctrl_o); end
    n_vec++; if (ma_address_o !== 48'd0) begin n_err++;
      $display("FAIL reset_addr: got %h want 0", ma_address_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  // Checks a completed load against the model's expectations.
  task automatic check_load(input string nm, input logic [47:0] base, input bit spam);
    int exp_lat;
    logic [47:0] ea, ga;
    logic [143:0] ek;
    exp_lat = 0;
    for (int r = 0; r < 3; r++) exp_lat += 1 + cfg_d[r] + cfg_g[r];
    ek = {cfg_data[2], cfg_data[1], cfg_data[0]};
    run_load(base, spam);
    n_vec++; if (obs_lat !== exp_lat) begin n_err++;
      $display("FAIL %s_latency: got %0d want %0d", nm, obs_lat, exp_lat); end
    n_vec++; if (obs_ndone !== 1) begin n_err++;
      $display("FAIL %s_done_count: got %0d want 1", nm, obs_ndone); end
    n_vec++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL %s_error: got %b want 0", nm, obs_err); end
    n_vec++; if (kernel_o !== ek) begin n_err++;
      $display("FAIL %s_kernel: got %h want %h", nm, kernel_o, ek); end
    n_vec++; if (kernel_valid_o !== 1'b1) begin n_err++;
      $display("FAIL %s_kvalid: got %b want 1", nm, kernel_valid_o); end
    n_vec++; if (obs_busy_acc !== 1'b1) begin n_err++;
      $display("FAIL %s_busy_accept: got %b want 1", nm, obs_busy_acc); end
    n_vec++; if (obs_kv_acc !== 1'b0) begin n_err++;
      $display("FAIL %s_kvalid_accept: got %b want 0", nm, obs_kv_acc); end
    n_vec++; if (obs_busy_end !== 1'b0) begin n_err++;
      $display("FAIL %s_busy_at_done: got %b want 0", nm, obs_busy_end); end
    n_vec++; if (gap_viol !== 0) begin n_err++;
      $display("FAIL %s_request_during_handshake: got %0d want 0", nm, gap_viol); end
    n_vec++; if (req_addr.size() !== 3) begin n_err++;
      $display("FAIL %s_request_count: got %0d want 3", nm, req_addr.size()); end
    for (int r = 0; r < 3; r++) begin
      ea = base + 48'(r * 3);
      ga = (r < req_addr.size()) ? req_addr[r] : 48'hx;
      n_vec++; if (ga !== ea) begin n_err++;
        $display("FAIL %s_addr%0d: got %h want %h", nm, r, ga, ea); end
      n_vec++; if (r < req_ctrl.size() && req_ctrl[r] !== 3'b000) begin n_err++;
        $display("FAIL %s_ctrl%0d: got %h want 0", nm, r, req_ctrl[r]); end
    end
  endtask

  task automatic test_nominal();
    set_cfg(2, 2, 2, 1, 48'h0001_0002_0003, 48'h0004_0005_0006, 48'h0007_0008_0009);
    check_load("nominal", 48'h10, 1'b0);
  endtask

  task automatic test_timeout();
    int exp_err_lat;
    set_cfg(2, 0, 0, 1, 48'hAAAA_0000_1111, 48'hBAD0_BAD0_BAD0, 48'hBAD1_BAD1_BAD1);
    exp_err_lat = (1 + 2 + 1) + 1 + TbTimeout;
    run_load(48'h40, 1'b0);
    n_vec++; if (obs_err_lat !== exp_err_lat) begin n_err++;
      $display("FAIL timeout_cycle: got %0d want %0d", obs_err_lat, exp_err_lat); end
    n_vec++; if (ma_enable_o !== 1'b0) begin n_err++;
      $display("FAIL timeout_enable: got %b want 0", ma_enable_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b want 0", busy_o); end
    n_vec++; if (error_o !== 1'b1) begin n_err++;
      $display("FAIL timeout_error_sticky: got %b want 1", error_o); end
    n_vec++; if (kernel_valid_o !== 1'b0) begin n_err++;
      $display("FAIL timeout_kvalid: got %b want 0", kernel_valid_o); end
    n_vec++; if (kernel_o[47:0] !== 48'hAAAA_0000_1111) begin n_err++;
      $display("FAIL timeout_partial_row0: got %h want aaaa00001111", kernel_o[47:0]); end
    n_vec++; if (obs_ndone !== 0) begin n_err++;
      $display("FAIL timeout_done_count: got %0d want 0", obs_ndone); end
    set_cfg(1, 1, 1, 1, 48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999);
    check_load("after_timeout", 48'h80, 1'b0);
    n_vec++; if (obs_err_acc !== 1'b0) begin n_err++;
      $display("FAIL restart_error_cleared: got %b want 0", obs_err_acc); end
  endtask

  task automatic test_wrap();
    set_cfg(1, 1, 1, 1, 48'hC0DE_0000_0001, 48'hC0DE_0000_0002, 48'hC0DE_0000_0003);
    check_load("wrap", 48'hFFFF_FFFF_FFFE, 1'b0);
  endtask

  task automatic test_sticky_handshake();
    set_cfg(1, 1, 1, 4, 48'h0101_0101_0101, 48'h0202_0202_0202, 48'h0303_0303_0303);
    check_load("sticky", 48'h200, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_cfg(1, 0, 0, 1, 48'h5555_5555_5555, 48'h6666_6666_6666, 48'h7777_7777_7777);
    model_clear();
    kernel_base_i = 48'h300;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 50 && req_n < 2; i++) tick();
    n_vec++; if (req_n !== 2) begin n_err++; $display("FAIL rstmid_reach_row1: got %0d want 2", req_n); end
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done_o); end
    n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL rstmid_error: got %b want 0", error_o); end
    n_vec++; if (ma_enable_o !== 1'b0) begin n_err++;
      $display("FAIL rstmid_enable: got %b want 0", ma_enable_o); end
    n_vec++; if (ma_address_o !== 48'd0) begin n_err++;
      $display("FAIL rstmid_addr: got %h want 0", ma_address_o); end
    n_vec++; if (kernel_o !== 144'd0) begin n_err++; $display("FAIL rstmid_kernel: got %h want 0", kernel_o); end
    n_vec++; if (kernel_valid_o !== 1'b0) begin n_err++;
      $display("FAIL rstmid_kvalid: got %b want 0", kernel_valid_o); end
    tick();
    set_cfg(1, 2, 1, 1, 48'h0A0A_0A0A_0A0A, 48'h0B0B_0B0B_0B0B, 48'h0C0C_0C0C_0C0C);
    check_load("after_reset", 48'h400, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_cfg(2, 2, 2, 1, 48'h0001_0002_0003, 48'h0004_0005_0006, 48'h0007_0008_0009);
    check_load("start_spam", 48'h10, 1'b1);
    set_cfg(1, 3, 2, 2, 48'hFACE_0000_0001, 48'hFACE_0000_0002, 48'hFACE_0000_0003);
    check_load("back_to_back", 48'h1234, 1'b1);
  endtask

  task automatic test_coincide();
    // Handshake on the last permitted WAIT cycle is still captured.
    set_cfg(1, TbTimeout, 1, 1, 48'hDEAD_0000_0000, 48'hDEAD_0000_0001, 48'hDEAD_0000_0002);
    check_load("coincide", 48'h500, 1'b0);
    // One cycle later is a timeout on row 0.
    set_cfg(TbTimeout + 1, 1, 1, 1, 48'h1, 48'h2, 48'h3);
    run_load(48'h600, 1'b0);
    n_vec++; if (obs_err_lat !== 1 + TbTimeout) begin n_err++;
      $display("FAIL late_hs_timeout_cycle: got %0d want %0d", obs_err_lat, 1 + TbTimeout); end
    repeat (4) tick();
  endtask

  task automatic test_random();
    logic [63:0] t;
    logic [47:0] base;
    logic [47:0] rd [3];
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < 3; r++) begin
        t = {$urandom(), $urandom()};
        rd[r] = t[47:0];
      end
      set_cfg($urandom_range(1, TbTimeout), $urandom_range(1, TbTimeout),
              $urandom_range(1, TbTimeout), $urandom_range(1, 3), rd[0], rd[1], rd[2]);
      t = {$urandom(), $urandom()};
      base = t[47:0];
      check_load("random", base, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      cfg_d[i] = 1;
      cfg_g[i] = 1;
      cfg_data[i] = '0;
    end
    test_reset();
    test_nominal();
    test_timeout();
    test_wrap();
    test_sticky_handshake();
    test_reset_mid();
    test_back_to_back();
    test_coincide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
